// File: rtl/wb_register_file_pkg.sv
// ---------------------------------------------------------------------------
// wb_register_file_pkg
// Constants shared by the MEM/WB pipeline register, the decoder and the
// writeback register file: data width, register address width, register
// count and the memToReg source encodings.
// ---------------------------------------------------------------------------
package wb_register_file_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int REG_ADDR_WIDTH = 3;
  localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;

  // memToReg encodings: which value the WB stage writes back.
  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_MEM = 1'b1;

endpackage : wb_register_file_pkg

// File: rtl/wb_register_file_if.sv
// ---------------------------------------------------------------------------
// wb_register_file_if
// Bundles the WB-side signals of the register file.
//   MEM/WB inputs : regWrite_WB, memToReg_WB, changeEnable, writeAddr_WB,
//                   aluResult_WB, memData_WB
//   ID read ports : readAddrA/B in, readDataA/B out
//   WB/EX outputs : writeData_WB, fwdValid, fwdAddr, fwdData
// Modports:
//   master - the pipeline side that drives the MEM/WB fields and read addresses
//   slave  - the register file itself
// ---------------------------------------------------------------------------
interface wb_register_file_if
  import wb_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = wb_register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = wb_register_file_pkg::REG_ADDR_WIDTH
);

  logic                  regWrite_WB;
  logic                  memToReg_WB;
  logic                  changeEnable;
  logic [ADDR_WIDTH-1:0] writeAddr_WB;
  logic [DATA_WIDTH-1:0] aluResult_WB;
  logic [DATA_WIDTH-1:0] memData_WB;

  logic [ADDR_WIDTH-1:0] readAddrA;
  logic [ADDR_WIDTH-1:0] readAddrB;
  logic [DATA_WIDTH-1:0] readDataA;
  logic [DATA_WIDTH-1:0] readDataB;

  logic [DATA_WIDTH-1:0] writeData_WB;
  logic                  fwdValid;
  logic [ADDR_WIDTH-1:0] fwdAddr;
  logic [DATA_WIDTH-1:0] fwdData;

  modport master (
    output regWrite_WB, memToReg_WB, changeEnable, writeAddr_WB,
           aluResult_WB, memData_WB, readAddrA, readAddrB,
    input  readDataA, readDataB, writeData_WB, fwdValid, fwdAddr, fwdData
  );

  modport slave (
    input  regWrite_WB, memToReg_WB, changeEnable, writeAddr_WB,
           aluResult_WB, memData_WB, readAddrA, readAddrB,
    output readDataA, readDataB, writeData_WB, fwdValid, fwdAddr, fwdData
  );

endinterface : wb_register_file_if

// File: rtl/wb_register_file_regfile_core.sv
// ---------------------------------------------------------------------------
// regfile_core
// Storage for the general registers: one synchronous write port and two raw
// asynchronous read ports. No bypass here; the top adds write-through.
//   clock, reset          - rising-edge clock, async active-high clear
//   writeEnable           - commit writeData to writeAddr on the edge
//   writeAddr, writeData  - write port
//   readAddrA/B           - read addresses
//   readDataA/B           - stored contents (pre-edge values)
// ---------------------------------------------------------------------------
module regfile_core
  import wb_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = wb_register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = wb_register_file_pkg::REG_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readAddrA,
  input  logic [ADDR_WIDTH-1:0] readAddrB,
  output logic [DATA_WIDTH-1:0] readDataA,
  output logic [DATA_WIDTH-1:0] readDataB
);

  localparam int NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NumRegs];

  // NOTE: the array is cleared by the asynchronous reset because every
  // register must read zero right after reset; that keeps it as flops rather
  // than a RAM, which cannot be reset. Sequential state uses non-blocking
  // assignments so all flops sample pre-edge values together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEnable) begin
      regs[writeAddr] <= writeData;
    end
  end

  assign readDataA = regs[readAddrA];
  assign readDataB = regs[readAddrB];

endmodule : regfile_core

// File: rtl/wb_register_file.sv
// ---------------------------------------------------------------------------
// wb_register_file
// Writeback stage consumer of the MEM/WB register. Selects ALU or load data,
// commits it to the register file when the pipeline advances, offers two
// ID-stage read ports with write-through bypass, and exports a registered
// copy of the last committed write for EX-stage forwarding.
//   clock   - rising-edge clock
//   reset   - async active-high, clears registers and forwarding state
//   wbBus   - wb_register_file_if.slave (MEM/WB fields, read ports, fwd outputs)
// ---------------------------------------------------------------------------
module wb_register_file
  import wb_register_file_pkg::*;
#(
  parameter int DATA_WIDTH = wb_register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = wb_register_file_pkg::REG_ADDR_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  wb_register_file_if.slave  wbBus
);

  logic                  commit;
  logic [DATA_WIDTH-1:0] writeData;
  logic [DATA_WIDTH-1:0] rawDataA;
  logic [DATA_WIDTH-1:0] rawDataB;

  // A stalled WB stage still holds valid control, so changeEnable gates both
  // the commit and the bypass.
  assign commit    = wbBus.regWrite_WB & wbBus.changeEnable;
  assign writeData = (wbBus.memToReg_WB == WB_SRC_MEM) ? wbBus.memData_WB
                                                        : wbBus.aluResult_WB;
  assign wbBus.writeData_WB = writeData;

  regfile_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clock       (clock),
    .reset       (reset),
    .writeEnable (commit),
    .writeAddr   (wbBus.writeAddr_WB),
    .writeData   (writeData),
    .readAddrA   (wbBus.readAddrA),
    .readAddrB   (wbBus.readAddrB),
    .readDataA   (rawDataA),
    .readDataB   (rawDataB)
  );

  // Write-through: a read of the register being committed this cycle sees
  // the new value before the array updates at the edge.
  assign wbBus.readDataA = (commit && (wbBus.readAddrA == wbBus.writeAddr_WB))
                           ? writeData : rawDataA;
  assign wbBus.readDataB = (commit && (wbBus.readAddrB == wbBus.writeAddr_WB))
                           ? writeData : rawDataB;

  // Forwarding copy: valid for exactly the cycle after a commit; address and
  // data hold their last committed values otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wbBus.fwdValid <= 1'b0;
      wbBus.fwdAddr  <= '0;
      wbBus.fwdData  <= '0;
    end else begin
      wbBus.fwdValid <= commit;
      if (commit) begin
        wbBus.fwdAddr <= wbBus.writeAddr_WB;
        wbBus.fwdData <= writeData;
      end
    end
  end

endmodule : wb_register_file

// File: doc/wb_register_file.md
Name: wb_register_file

Overview:
Writeback-side consumer of the MEM/WB pipeline register. It selects the writeback data from the ALU result or the memory load data, and commits it to the 8-entry general register file. It also provides two ID-stage read ports with same-cycle write-through bypass. A registered copy of the last committed write is exported for EX-stage forwarding.

Parameters:
DATA_WIDTH, 16, width of each general register and of the writeback data path
ADDR_WIDTH, 3, register address width; NUM_REGS = 2**ADDR_WIDTH (8)

Ports:
clock  input  1  single clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
regWrite_WB  input  1  writeback requested (from MEM/WB register)
memToReg_WB  input  1  1 = write memData_WB, 0 = write aluResult_WB
changeEnable  input  1  pipeline advance strobe; a write commits only when high
writeAddr_WB  input  ADDR_WIDTH  destination register
aluResult_WB  input  DATA_WIDTH  ALU result carried to WB
memData_WB  input  DATA_WIDTH  load data carried to WB
readAddrA  input  ADDR_WIDTH  ID read port A address
readAddrB  input  ADDR_WIDTH  ID read port B address
readDataA  output  DATA_WIDTH  port A data (combinational)
readDataB  output  DATA_WIDTH  port B data (combinational)
writeData_WB  output  DATA_WIDTH  selected writeback value (combinational)
fwdValid  output  1  fwdAddr/fwdData hold a committed write from the previous edge
fwdAddr  output  ADDR_WIDTH  address of that write
fwdData  output  DATA_WIDTH  data of that write

Behaviour:
- Reset (asynchronous, while reset=1):
  - all NUM_REGS registers = 0
  - fwdValid = 0, fwdAddr = 0, fwdData = 0
  - no write commits while reset is asserted, including reset asserted mid-cycle
- writeData_WB = memToReg_WB ? memData_WB : aluResult_WB. Pure mux, no arithmetic, width DATA_WIDTH.
- Commit condition: commit = regWrite_WB & changeEnable.
- On the rising clock edge with commit=1, reg[writeAddr_WB] <= writeData_WB.
- A stalled WB (changeEnable=0) must not write, even though the MEM/WB register is holding valid control.
- Every register, including R0, is writable. There is no hardwired zero.
- Read ports:
  - readDataX = reg[readAddrX], except when commit=1 and readAddrX == writeAddr_WB; then readDataX = writeData_WB (write-through bypass).
  - Both ports may bypass in the same cycle.
  - Bypass is gated by changeEnable exactly as the commit is.
- Forwarding register, updated every rising edge:
  - fwdValid <= commit
  - if commit: fwdAddr <= writeAddr_WB and fwdData <= writeData_WB; otherwise fwdAddr/fwdData hold their previous values
  - latency: a commit at edge N shows fwdValid=1 during cycle N+1 only, unless another commit occurs at N+1
- Write to address X and read of X in the same cycle returns new data. The stored value updates at the edge.
- memToReg_WB is ignored when regWrite_WB=0.
- After reset is released, the first rising edge may commit.

Decomposition:
- Shared package holds:
  - DATA_WIDTH=16, REG_ADDR_WIDTH=3, NUM_REGS=8
  - WB_SRC_ALU=1'b0, WB_SRC_MEM=1'b1 encodings for memToReg
  These are the same constants used by the MEM/WB register and the decoder.
- One natural sub-module: regfile_core, holding the register array plus write port and raw read ports, without bypass.
- Mux, bypass and forwarding register stay in the wb_register_file top.

Test Plan:
- Reset released, no writes: readAddrA=0..7 gives readDataA=0x0000 for every register; fwdValid=0.
- regWrite=1, memToReg=0, changeEnable=1, addr=3, alu=0x1234, mem=0xBEEF, one edge: a later read of R3 returns 0x1234, fwdValid=1, fwdAddr=3, fwdData=0x1234. The next idle edge gives fwdValid=0 and fwdData still 0x1234.
- memToReg=1, addr=5, mem=0xBEEF, readAddrA=readAddrB=5 in the same cycle: both read ports and writeData_WB show 0xBEEF before the edge; after the edge R5=0xBEEF.
- regWrite=1, changeEnable=0, addr=2, alu=0x00FF, held 3 cycles: R2 stays 0, no bypass on readAddrA=2, fwdValid stays 0. Raising changeEnable for one edge gives R2=0x00FF.
- Back-to-back commits R1=0x0001 then R1=0x0002: R1 reads 0x0002, and fwdValid stays 1 for both following cycles with fwdData 0x0001 then 0x0002.
- Mid-operation: R7=0xAAAA written, then reset pulsed asynchronously between edges: R7 and fwd outputs read 0 immediately, without waiting for a clock. A commit presented on the edge during reset is discarded.
